uart_rx: RTL

//  UART receive engine, 8N1-style, LSB first, 16x oversampled with mid-bit sampling.

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled, mid-bit sampled, LSB first, 8N1-style framing.
// Good bytes are delivered on a valid/ready handshake; framing errors and overruns pulse for one cycle.
module uart_rx #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_bit,
   input  logic [7:0]           freq_divider,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             div_cnt_q, div_cnt_d;
   logic                   tick_q, tick_d;
   logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
   logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   rx_s;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Divider uses ">=" so a smaller freq_divider takes effect at once instead of wrapping.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx_bit};
      if (div_cnt_q >= freq_divider) begin
         tick_d    = 1'b1;
         div_cnt_d = '0;
      end else begin
         tick_d    = 1'b0;
         div_cnt_d = div_cnt_q + 8'd1;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default here first, so no path can leave one unassigned and infer a latch.
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      if (tick_q) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d  = ST_START;
                  os_cnt_d = '0;
               end
            end
            ST_START: begin
               if (os_cnt_q == OS_HALF) begin
                  if (rx_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d   = ST_DATA;
                     os_cnt_d  = '0;
                     bit_cnt_d = '0;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_DATA: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  shift_d[DATA_BITS-1] = rx_s;
                  for (int i = 0; i < DATA_BITS - 1; i++) begin
                     shift_d[i] = shift_q[i+1];
                  end
                  if (bit_cnt_q == BC_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BC_W'(1);
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_STOP: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  if (rx_s) begin
                     state_d = ST_IDLE;
                     // A byte accepted on this same edge frees the slot for the new one.
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_WAIT_HIGH;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the reset is sampled on the clock edge only; there is no storage array here, so every flop is cleared.
      if (!reset) begin
         state_q     <= ST_IDLE;
         sync_q      <= '1;
         div_cnt_q   <= '0;
         tick_q      <= 1'b0;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q     <= state_d;
         sync_q      <= sync_d;
         div_cnt_q   <= div_cnt_d;
         tick_q      <= tick_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
